// File: rtl/rvfi_mon_pkg.sv
// rtl/rvfi_mon_pkg.sv - shared types and constants for the RVFI retire monitor
package rvfi_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

  localparam int         ORDER_W    = 64;
  localparam int         INSN_W     = 32;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/rvfi_mon_chan_check.sv
// rtl/rvfi_mon_chan_check.sv - combinational completeness/order check for one retire channel
// Optional build macro: RVFI_MON_SYSTEM_SKIP_EN (SYSTEM opcodes exempt from completeness)
module rvfi_mon_chan_check
  import rvfi_mon_pkg::*;
#(
  parameter int CHAN = 0
) (
  input  logic               valid,
  input  logic               prev_valid,
  input  logic [ORDER_W-1:0] order,
  input  logic [ORDER_W-1:0] exp_base,
  input  logic [INSN_W-1:0]  insn,
  input  logic               trap,
  input  logic               spec_valid,
  input  logic               spec_trap,
  output logic               err_complete,
  output logic               err_order
);

`ifdef RVFI_MON_SYSTEM_SKIP_EN
  localparam bit SYSTEM_SKIP = 1'b1;
`else
  localparam bit SYSTEM_SKIP = 1'b0;
`endif

  logic is_system;
  logic unused_insn_hi;

  assign is_system      = (insn[6:0] == OPC_SYSTEM);
  assign unused_insn_hi = ^insn[INSN_W-1:7];

  // A retired non-trapping instruction must be one the ISA model also accepts.
  assign err_complete = valid && !trap && !(spec_valid && !spec_trap) && !(SYSTEM_SKIP && is_system);

  // Channels pack from 0 and each carries the next sequential order number.
  assign err_order = valid && (!prev_valid || (order != exp_base + ORDER_W'(CHAN)));

endmodule

// File: rtl/rvfi_retire_monitor.sv
// rtl/rvfi_retire_monitor.sv - RVFI retirement completeness/ordering/liveness monitor (top)
// Optional build macro: RVFI_MON_SYSTEM_SKIP_EN (handled in rvfi_mon_chan_check)
module rvfi_retire_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [ORDER_W*NRET-1:0]   rvfi_order,
  input  logic [INSN_W*NRET-1:0]    rvfi_insn,
  input  logic [NRET-1:0]           rvfi_trap,
  input  logic [NRET-1:0]           spec_valid,
  input  logic [NRET-1:0]           spec_trap,
  output logic                      err_complete,
  output logic                      err_order,
  output logic                      err_live,
  output logic [2:0]                err_chan,
  output logic [31:0]               retired,
  output logic [1:0]                mon_state
);

  mon_state_e         state, state_nx;
  logic [ORDER_W-1:0] exp_order, exp_order_nx;
  logic [31:0]        retired_nx;
  logic [31:0]        idle_cnt, idle_cnt_nx;
  logic               err_complete_nx, err_order_nx, err_live_nx;
  logic [2:0]         err_chan_nx;

  logic [NRET-1:0]    prev_valid, comp_err, ord_err;
  logic [3:0]         pop;
  logic [32:0]        ret_sum;
  logic               any_valid, live_hit;
  logic [2:0]         first_chan;

  always_comb begin
    prev_valid    = '1;
    for (int i = 1; i < NRET; i++) prev_valid[i] = rvfi_valid[i-1];
  end

  for (genvar g = 0; g < NRET; g++) begin : g_chan
    rvfi_mon_chan_check #(.CHAN(g)) u_chk (
      .valid        (rvfi_valid[g]),
      .prev_valid   (prev_valid[g]),
      .order        (rvfi_order[ORDER_W*g +: ORDER_W]),
      .exp_base     (exp_order),
      .insn         (rvfi_insn[INSN_W*g +: INSN_W]),
      .trap         (rvfi_trap[g]),
      .spec_valid   (spec_valid[g]),
      .spec_trap    (spec_trap[g]),
      .err_complete (comp_err[g]),
      .err_order    (ord_err[g])
    );
  end

  always_comb begin
    pop        = '0;
    first_chan = '0;
    for (int i = 0; i < NRET; i++) pop = pop + 4'(rvfi_valid[i]);
    // Scan downward so the lowest offending channel wins.
    for (int i = NRET - 1; i >= 0; i--) begin
      if (comp_err[i] || ord_err[i]) first_chan = 3'(i);
    end
  end

  assign any_valid = |rvfi_valid;
  assign ret_sum   = {1'b0, retired} + 33'(pop);
  assign live_hit  = (TIMEOUT != 0) && !any_valid && (idle_cnt == 32'(TIMEOUT - 1));

  always_comb begin
    state_nx        = state;
    exp_order_nx    = exp_order;
    retired_nx      = retired;
    idle_cnt_nx     = idle_cnt;
    err_complete_nx = err_complete;
    err_order_nx    = err_order;
    err_live_nx     = err_live;
    err_chan_nx     = err_chan;
    case (state)
      ST_IDLE: state_nx = ST_RUN;
      ST_RUN: begin
        exp_order_nx = exp_order + ORDER_W'(pop);
        retired_nx   = ret_sum[32] ? 32'hFFFF_FFFF : ret_sum[31:0];
        idle_cnt_nx  = (any_valid || TIMEOUT == 0) ? 32'd0 : idle_cnt + 32'd1;
        if ((|comp_err) || (|ord_err) || live_hit) begin
          state_nx        = ST_FAIL;
          err_complete_nx = |comp_err;
          err_order_nx    = |ord_err;
          err_live_nx     = live_hit;
          err_chan_nx     = first_chan;
        end
      end
      ST_FAIL: state_nx = ST_FAIL;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      exp_order    <= '0;
      retired      <= '0;
      idle_cnt     <= '0;
      err_complete <= 1'b0;
      err_order    <= 1'b0;
      err_live     <= 1'b0;
      err_chan     <= '0;
    end else begin
      state        <= state_nx;
      exp_order    <= exp_order_nx;
      retired      <= retired_nx;
      idle_cnt     <= idle_cnt_nx;
      err_complete <= err_complete_nx;
      err_order    <= err_order_nx;
      err_live     <= err_live_nx;
      err_chan     <= err_chan_nx;
    end
  end

  assign mon_state = state;

endmodule

// File: doc/rvfi_retire_monitor.md
RVFI_RETIRE_MONITOR -- requirements
Module: rvfi_retire_monitor

Interface
REQ-001 SHALL have parameter NRET, default 2, number of retirement channels (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, max consecutive idle RUN cycles before liveness error; 0 disables the check.
REQ-003 SHALL have port clk input 1, clock.
REQ-004 SHALL have port reset input 1, reset, synchronous, active-low.
REQ-005 SHALL have port rvfi_valid input NRET, per-channel retire valid.
REQ-006 SHALL have port rvfi_order input 64*NRET, per-channel retire order; channel i in bits [64i+63:64i].
REQ-007 SHALL have port rvfi_insn input 32*NRET, per-channel instruction word.
REQ-008 SHALL have port rvfi_trap input NRET, per-channel trap flag.
REQ-009 SHALL have port spec_valid input NRET, per-channel ISA-spec valid.
REQ-010 SHALL have port spec_trap input NRET, per-channel ISA-spec trap.
REQ-011 SHALL have port err_complete output 1, sticky completeness error.
REQ-012 SHALL have port err_order output 1, sticky ordering/packing error.
REQ-013 SHALL have port err_live output 1, sticky liveness error.
REQ-014 SHALL have port err_chan output 3, lowest offending channel index of first error.
REQ-015 SHALL have port retired output 32, count of retired instructions.
REQ-016 SHALL have port mon_state output 2, FSM state (IDLE=0, RUN=1, FAIL=2).

Function
REQ-017 SHALL implement FSM IDLE -> RUN on first cycle with reset high; RUN -> FAIL on any error; FAIL held until reset.
REQ-018 SHALL evaluate no checks in IDLE (first post-reset cycle masked).
REQ-019 SHALL flag completeness on channel i when rvfi_valid[i] and !rvfi_trap[i] and !(spec_valid[i] and !spec_trap[i]).
REQ-020 SHALL flag order error when rvfi_valid[i] and !rvfi_valid[i-1] (channels must pack from 0).
REQ-021 SHALL flag order error when valid channel i has rvfi_order != exp_order + i.
REQ-022 SHALL hold internal 64-bit exp_order, reset 0, advanced in RUN by popcount(rvfi_valid), wrapping modulo 2^64.
REQ-023 SHALL increment retired by popcount(rvfi_valid) in RUN, saturating at 32'hFFFF_FFFF.
REQ-024 SHALL count consecutive RUN cycles with no valid channel; clear on any valid; set err_live when count reaches TIMEOUT.
REQ-025 SHALL register all error flags: set on the clock edge following the offending inputs (1-cycle latency).
REQ-026 SHALL set every simultaneous error flag; err_chan takes lowest channel with completeness or order error, 0 for liveness-only.
REQ-027 SHALL freeze exp_order, retired, idle counter and err_chan in FAIL; further errors ignored.

Reset
REQ-028 SHALL on reset low at clk edge set mon_state=IDLE, err_*=0, err_chan=0, retired=0, exp_order=0, idle count=0.
REQ-029 SHALL let reset mid-operation, including in FAIL, override all other updates in that cycle.

Configuration
REQ-030 SHALL, with RVFI_MON_SYSTEM_SKIP_EN defined, exempt channels whose rvfi_insn[6:0]==7'b1110011 from completeness check (ordering still checked).
REQ-031 SHALL, without RVFI_MON_SYSTEM_SKIP_EN, apply completeness to all opcodes.

Structure
REQ-032 SHALL place state enum, ORDER_W=64, INSN_W=32 and OPC_SYSTEM=7'b1110011 in package rvfi_mon_pkg.
REQ-033 SHALL use one sub-module rvfi_mon_chan_check (combinational per-channel completeness/order check), instantiated NRET times.

Verification
REQ-034 NRET=2: orders 0,1 then 2,3 valid, spec_valid=1 -> no errors, retired=4, mon_state=RUN.
REQ-035 NRET=2: rvfi_valid=2'b10 -> err_order=1, err_chan=1, mon_state=FAIL next cycle.
REQ-036 Ch0 valid, insn 32'h0000_0073, spec_valid=0: with RVFI_MON_SYSTEM_SKIP_EN -> no error; without -> err_complete=1, err_chan=0.
REQ-037 TIMEOUT=16, no valid for 16 RUN cycles -> err_live=1 after 16th idle cycle; valid on 15th -> no error.
REQ-038 Order skip: ch0 order 5 when exp_order=4 plus ch1 completeness fail -> err_order=1, err_complete=1, err_chan=0.
REQ-039 Reset low one cycle while in FAIL -> all flags 0, retired=0, mon_state=IDLE, then RUN.
